// File: rtl/tc_serializer.sv
// Parallel-to-serial feeder for the serial two's-complement stage: one clear pulse, then the word LSB-first.
// Optional sign extension of each frame by EXT copies of the MSB when TC_SER_SIGNEXT_EN is defined.
module tc_serializer #(
  parameter int W   = 8,
  parameter int EXT = 2
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         ser_bit,
  output logic         bit_valid,
  output logic         frame_clr,
  output logic         last
);

  localparam int CW = $clog2(W + EXT + 1);

`ifdef TC_SER_SIGNEXT_EN
  typedef enum logic [1:0] {IDLE, CLR, SHIFT, EXTD} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLR, SHIFT} state_t;
`endif

  state_t         state, state_n;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           msb_cyc;
`ifdef TC_SER_SIGNEXT_EN
  logic           msb;
`endif

  assign msb_cyc = (state == SHIFT) && (cnt == CW'(W - 1));
  assign accept  = din_valid && din_ready;

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef TC_SER_SIGNEXT_EN
      msb   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        shreg <= din;
        cnt   <= '0;
`ifdef TC_SER_SIGNEXT_EN
        // shreg is drained by the time EXTD runs, so keep the sign bit aside
        msb   <= din[W-1];
`endif
      end else if (state == SHIFT) begin
        shreg <= shreg >> 1;
        cnt   <= cnt + CW'(1);
`ifdef TC_SER_SIGNEXT_EN
      end else if (state == EXTD) begin
        cnt   <= cnt + CW'(1);
`endif
      end
    end
  end

  always_comb begin
    state_n   = state;
    din_ready = 1'b0;
    ser_bit   = 1'b0;
    bit_valid = 1'b0;
    frame_clr = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        din_ready = !r;
        if (din_valid && !r) state_n = CLR;
      end
      CLR: begin
        frame_clr = 1'b1;
        state_n   = SHIFT;
      end
      SHIFT: begin
        ser_bit   = shreg[0];
        bit_valid = 1'b1;
`ifdef TC_SER_SIGNEXT_EN
        if (msb_cyc) state_n = EXTD;
`else
        if (msb_cyc) begin
          last      = 1'b1;
          din_ready = !r;
          state_n   = (din_valid && !r) ? CLR : IDLE;
        end
`endif
      end
`ifdef TC_SER_SIGNEXT_EN
      EXTD: begin
        ser_bit   = msb;
        bit_valid = 1'b1;
        if (cnt == CW'(W + EXT - 1)) begin
          last      = 1'b1;
          din_ready = !r;
          state_n   = (din_valid && !r) ? CLR : IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tc_serializer.sv
// Self-checking bench for tc_serializer: a queue of expected per-cycle outputs built from each accepted word.
module tb_tc_serializer;
  localparam int W   = 8;
  localparam int EXT = 2;
`ifdef TC_SER_SIGNEXT_EN
  localparam int FL = W + EXT;
`else
  localparam int FL = W;
`endif
  localparam logic [4:0] IDLE_T = 5'b10000; // {din_ready, frame_clr, bit_valid, ser_bit, last}

  logic         t_clk = 1'b0;
  logic         r;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready, ser_bit, bit_valid, frame_clr, last;

  int           checks = 0;
  int           failures = 0;
  logic [4:0]   q[$];
  logic [4:0]   cur;
  logic         comp_on, seen;
  logic [W-1:0] comp_word;
  int           nb;
  logic         done;

  tc_serializer #(.W(W), .EXT(EXT)) dut (
    .t_clk(t_clk), .r(r), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .ser_bit(ser_bit), .bit_valid(bit_valid), .frame_clr(frame_clr), .last(last)
  );

  always #5 t_clk = ~t_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected frame: one clear cycle, then FL bits (sign-extended past W when enabled).
  task automatic push_frame(input logic [W-1:0] d);
    logic b, lst;
    q.push_back(5'b01000);
    for (int i = 0; i < FL; i++) begin
      b   = (i < W) ? d[i] : d[W-1];
      lst = (i == FL - 1);
      q.push_back({lst, 1'b0, 1'b1, b, lst});
    end
  endtask

  task automatic cyc_check(input string tag);
    if (r) cur = 5'b00000;
    else if (q.size() > 0) cur = q.pop_front();
    else cur = IDLE_T;
    chk(tag, {27'd0, din_ready, frame_clr, bit_valid, ser_bit, last}, {27'd0, cur});
    if (comp_on && bit_valid) begin
      if (nb < W) comp_word[nb] = ser_bit ^ seen;
      seen = seen | ser_bit;
      nb++;
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input string tag);
    if (!r && cur[4] && v) push_frame(d);
    din_valid = v;
    din       = d;
    @(negedge t_clk);
    cyc_check(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, '0, tag);
    chk({tag, "_drained"}, q.size(), 0);
    step(1'b0, '0, {tag, "_idle"});
  endtask

  initial begin
    r = 1'b1; din_valid = 1'b0; din = '0; cur = '0;
    comp_on = 1'b0; seen = 1'b0; comp_word = '0; nb = 0; done = 1'b0;

    // reset and idle
    repeat (3) begin @(negedge t_clk); cyc_check("reset"); end
    r = 1'b0;
    repeat (2) step(1'b0, '0, "idle");

    // single word with a chained complementer
    comp_on = 1'b1;
    step(1'b1, 8'h06, "single");
    drain("single");
    comp_on = 1'b0;
    chk("complement", {24'd0, comp_word}, 32'h0000_00FA);
    chk("single_bits", nb, FL);

    // back-to-back: 8'h80 presented only on the last bit of 8'h01
    step(1'b1, 8'h01, "b2b");
    for (int i = 0; i < 30 && !done; i++) begin
      if (cur[0]) begin step(1'b1, 8'h80, "b2b"); done = 1'b1; end
      else step(1'b1, 8'h01, "b2b");
    end
    chk("b2b_reached", {31'd0, done}, 1);
    drain("b2b");

    // busy ignore: 8'hFF held while 8'h06 is in flight
    step(1'b1, 8'h06, "busy");
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (cur[4]) done = 1'b1;
      step(1'b1, 8'hFF, "busy");
    end
    chk("busy_accepted", {31'd0, done}, 1);
    drain("busy");

    // reset during bit 3 of 8'hA5
    step(1'b1, 8'hA5, "midrst");
    repeat (4) step(1'b0, '0, "midrst");
    r = 1'b1;
    q.delete();
    #1;
    chk("midrst_async", {27'd0, din_ready, frame_clr, bit_valid, ser_bit, last}, 0);
    @(negedge t_clk);
    cyc_check("midrst_hold");
    r = 1'b0;
    repeat (FL + 3) step(1'b0, '0, "post_rst");

    // random traffic
    repeat (80) step(1'($urandom_range(0, 1)), W'($urandom), "random");
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
